cache_refill: RTL

Line-refill engine sitting directly downstream of the cache controller FSM. On a miss, it fetches one full cache line from main memory through a req/ack handshake and writes each word into the cache data array. Words are returned critical-word-first. It signals completion so the controller can raise `ready`. Optionally, it writes back a dirty victim line before the refill.

---
 rtl/cache_refill.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cache_refill.sv
// cache_refill: line-refill engine behind the cache controller FSM.
// On a miss it reads one cache line from memory over a req/ack handshake,
// critical word first, and writes every returned word into the cache data array.
// Optional writeback of a dirty victim line is enabled by defining CACHE_REFILL_WB_EN.
//
// Ports:
//   clock, reset        sole clock; synchronous active-high reset
//   start               miss request, sampled only when idle
//   miss_addr           byte address of the missing word (latched on start)
//   dirty, victim_addr  victim line state/address (latched on start; writeback build only)
//   line_rdata          cache array read data for line_idx (writeback build only)
//   busy, done          engine active / one-cycle completion pulse
//   first_word          one-cycle pulse with the first refill write strobe
//   mem_req/we/addr/wdata, mem_rdata, mem_ack   memory handshake
//   line_we/idx/wdata   cache array write port
module cache_refill #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned LINE_WORDS = 4,
   localparam int unsigned OFF_W     = $clog2(LINE_WORDS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic              dirty,
   input  logic [ADDR_W-1:0] victim_addr,
   input  logic [DATA_W-1:0] line_rdata,
   output logic              busy,
   output logic              done,
   output logic              first_word,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              line_we,
   output logic [OFF_W-1:0]  line_idx,
   output logic [DATA_W-1:0] line_wdata
);

   localparam int unsigned BASE_W = ADDR_W - OFF_W - 2;
   localparam logic [OFF_W:0] LastCnt = (OFF_W + 1)'(LINE_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StEvict, StFill, StDone} state_e;

   state_e              state_q, state_d;
   logic [OFF_W:0]      cnt_q, cnt_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [BASE_W-1:0]   base_q, base_d;
   logic [OFF_W-1:0]    fill_idx;
   logic                cnt_last;

   // Critical-word-first order: wraps inside the line, never carries into base.
   assign fill_idx   = off_q + cnt_q[OFF_W-1:0];
   assign cnt_last   = (cnt_q == LastCnt);
   assign line_wdata = mem_rdata;

`ifdef CACHE_REFILL_WB_EN
   logic [BASE_W-1:0] vbase_q, vbase_d;
   logic              unused_bits;
   assign unused_bits = ^{miss_addr[1:0], victim_addr[OFF_W+1:0]};
`else
   logic              unused_bits;
   assign unused_bits = ^{miss_addr[1:0], dirty, victim_addr, line_rdata};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         off_q   <= '0;
         base_q  <= '0;
`ifdef CACHE_REFILL_WB_EN
         vbase_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         base_q  <= base_d;
`ifdef CACHE_REFILL_WB_EN
         vbase_q <= vbase_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      off_d      = off_q;
      base_d     = base_q;
`ifdef CACHE_REFILL_WB_EN
      vbase_d    = vbase_q;
`endif
      busy       = 1'b0;
      done       = 1'b0;
      first_word = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      line_we    = 1'b0;
      line_idx   = '0;

      case (state_q)
         StIdle: begin
            if (start) begin
               base_d = miss_addr[ADDR_W-1:OFF_W+2];
               off_d  = miss_addr[OFF_W+1:2];
               cnt_d  = '0;
`ifdef CACHE_REFILL_WB_EN
               vbase_d = victim_addr[ADDR_W-1:OFF_W+2];
               state_d = dirty ? StEvict : StFill;
`else
               state_d = StFill;
`endif
            end
         end
`ifdef CACHE_REFILL_WB_EN
         StEvict: begin
            busy      = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {vbase_q, cnt_q[OFF_W-1:0], 2'b00};
            line_idx  = cnt_q[OFF_W-1:0];
            mem_wdata = line_rdata;
            if (mem_ack) begin
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = StFill;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
`endif
         StFill: begin
            busy       = 1'b1;
            mem_req    = 1'b1;
            mem_addr   = {base_q, fill_idx, 2'b00};
            line_idx   = fill_idx;
            line_we    = mem_ack;
            first_word = mem_ack && (cnt_q == '0);
            if (mem_ack) begin
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StDone: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule
